// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider (clk_div_n).
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Run-control state: halted parks the counter at N-1, ready to wrap.
  typedef enum logic {
    RUN_HALTED = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_t;

  // Waveform reference values shared with the testbench.
  localparam int   WAVE_DEFAULT_DIV = 3;
  localparam div_t WAVE_RESET_DIV   = div_t'(WAVE_DEFAULT_DIV);

  // Number of posedge-register high cycles for a divisor n.
  function automatic int wave_high_cycles(input int n);
    return n / 2;
  endfunction

  function automatic bit div_is_legal(input int n);
    return n >= MIN_DIV;
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow divisor register for clk_div_n: legality check, pending flag and
// error pulse; the top module hands over the shadow value on its apply strobe.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div_new,
  input  logic             apply,
  output logic [DIV_W-1:0] shadow_div,
  output logic             pending,
  output logic             err
);

  logic legal;

  assign legal = (div_new >= DIV_W'(MIN_DIV));

  // A legal load always wins over a same-edge apply so it lands on the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_div <= DIV_W'(MIN_DIV);
      pending    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= load & ~legal;
      if (load && legal) begin
        shadow_div <= div_new;
        pending    <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with tick output and glitch-free
// divisor/enable changes. Optional odd-N 50% duty via `CLK_DIV_ODD_DUTY50_EN.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             clk_q,
  output logic             tick_o,
  output logic [DIV_W-1:0] div_cur_o,
  output logic             load_pending_o,
  output logic             div_err_o,
  output logic             running_o
);

  if (DIV_W < 2 || DIV_W > 30) begin : g_bad_width
    $error("clk_div_n: DIV_W must be in 2..30");
  end
  if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV > ((1 << DIV_W) - 1)) begin : g_bad_default
    $error("clk_div_n: DEFAULT_DIV out of range 2..2^DIV_W-1");
  end

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

  run_state_t       state, state_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [DIV_W-1:0] div_cur, div_next;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] shadow_div;
  logic             pending;
  logic             pos_q, pos_next;
  logic             tick_q;
  logic             at_last;
  logic             wrap, hold, idle_apply, apply;

  assign half    = div_cur >> 1;
  assign at_last = (cnt == div_cur - 1'b1);
  assign apply   = pending & (wrap | idle_apply);

  clk_div_shadow #(
    .DIV_W(DIV_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load_i),
    .div_new   (div_i),
    .apply     (apply),
    .shadow_div(shadow_div),
    .pending   (pending),
    .err       (div_err_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN_HALTED;
    end else begin
      state <= state_next;
    end
  end

  // Enable is only honoured at the period boundary, so a dropped en_i lets the
  // current period finish before the counter parks at N-1.
  always_comb begin
    state_next = state;
    wrap       = 1'b0;
    hold       = 1'b0;
    idle_apply = 1'b0;
    case (state)
      RUN_ACTIVE: begin
        if (at_last) begin
          if (en_i) begin
            wrap = 1'b1;
          end else begin
            hold       = 1'b1;
            state_next = RUN_HALTED;
          end
        end
      end
      RUN_HALTED: begin
        if (en_i) begin
          wrap       = 1'b1;
          state_next = RUN_ACTIVE;
        end else if (pending) begin
          idle_apply = 1'b1;
        end
      end
      default: state_next = RUN_HALTED;
    endcase
  end

  always_comb begin
    div_next = apply ? shadow_div : div_cur;
    cnt_next = cnt;
    pos_next = pos_q;
    if (wrap) begin
      cnt_next = '0;
      pos_next = 1'b1;
    end else if (idle_apply) begin
      cnt_next = shadow_div - 1'b1;
      pos_next = 1'b0;
    end else if (hold || state == RUN_HALTED) begin
      pos_next = 1'b0;
    end else begin
      cnt_next = cnt + 1'b1;
      if (cnt + 1'b1 == half) begin
        pos_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= RESET_DIV - 1'b1;
      div_cur <= RESET_DIV;
      pos_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      div_cur <= div_next;
      pos_q   <= pos_next;
      tick_q  <= wrap;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;
  logic odd_stretch_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Masks a stale negedge sample on the reset edge and for even divisors.
  always_ff @(posedge clk) begin
    if (rst) begin
      odd_stretch_q <= 1'b0;
    end else begin
      odd_stretch_q <= div_next[0];
    end
  end

  assign clk_q = pos_q | (neg_q & odd_stretch_q);
`else
  assign clk_q = pos_q;
`endif

  assign tick_o         = tick_q;
  assign div_cur_o      = div_cur;
  assign load_pending_o = pending;
  assign running_o      = (state == RUN_ACTIVE);

endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
- Parametrised integer clock divider; next generation of the fixed divide-by-3 block.
- Divides `clk` by a runtime-programmable N (2..2^DIV_W-1).
- Divisor updates are glitch-free, applied only at output-period boundaries; enable/disable is glitch-free.
- Produces a divided clock plus a one-cycle tick for same-domain logic. Sits in the cdc/clock utility area feeding slow-domain consumers.

Parameters:
- DIV_W, 8, width of the divisor.
- DEFAULT_DIV, 3, divisor after reset; legal range 2..2^DIV_W-1, elaboration error otherwise.

Ports:
- clk  in  1  source clock.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  run request.
- div_i  in  DIV_W  new divisor value.
- div_load_i  in  1  one-cycle strobe; captures div_i.
- clk_q  out  1  divided clock.
- tick_o  out  1  one-cycle pulse, high in the cycle clk_q rises.
- div_cur_o  out  DIV_W  divisor currently in effect.
- load_pending_o  out  1  shadow divisor waiting for a boundary.
- div_err_o  out  1  one-cycle pulse; illegal divisor was rejected.
- running_o  out  1  divider is producing periods.

Behaviour:
- Interface: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset (any cycle, including mid-period): cnt=DEFAULT_DIV-1, clk_q=0, tick_o=0, div_cur_o=DEFAULT_DIV, load_pending_o=0, div_err_o=0, running_o=0. Takes effect at the same edge.
- Let N=div_cur_o and H=floor(N/2). The counter cnt runs 0..N-1.
- Wrap edge (cnt==N-1 and advancing):
  - cnt<=0, clk_q<=1, tick_o<=1.
  - If load_pending_o: N<=shadow, pending<=0.
- Edge where cnt advances to H: clk_q<=0.
- All other edges: cnt<=cnt+1; tick_o<=0.
- Resulting waveform:
  - Even N: exact 50% duty.
  - Odd N: high H cycles, low N-H cycles.
  - N=2: high 1 cycle, low 1 cycle.
- Run control:
  - running_o sets at the first wrap edge with en_i=1.
  - From reset, en_i=1 gives clk_q rising one cycle after rst falls.
  - en_i=0 while running: the current period completes. At cnt==N-1 the counter holds instead of wrapping; clk_q stays 0, running_o<=0.
  - While halted, re-asserting en_i wraps at the next edge.
- Divisor load:
  - div_load_i with div_i>=2: shadow<=div_i, load_pending_o<=1.
  - Load while already pending overwrites the shadow.
  - Load with div_i<2: ignored; div_err_o pulses one cycle; shadow and pending unchanged.
  - Load coinciding with a wrap edge: takes effect at the next wrap, never the current one.
  - Load while halted: applied on the next edge; cnt<=new N-1 so re-enable behaves as from reset.
- Invariants:
  - clk_q never pulses shorter than 1 clk cycle.
  - No period mixes old and new N.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined: add a negedge-clk flop sampling the posedge clk_q. For odd N, output clk_q = posedge_q OR negedge_q, giving exactly N/2 cycles high (e.g. 1.5 cycles for N=3). For even N, output = posedge_q only. The negedge flop is also reset by rst.
- Not defined: single posedge register; odd-N duty as in Behaviour.
- tick_o is unaffected either way.

Decomposition:
- Package clk_div_pkg:
  - MIN_DIV=2.
  - Default DIV_W.
  - typedef for the divisor type.
  - Waveform-check helper constants for the bench.
- One sub-module, clk_div_shadow: shadow register, pending flag, legality check and div_err_o; hands the new divisor to the counter on the wrap strobe.
- Counter and output logic stay in the top module.

Test Plan:
- Reset release with en_i=1, default N=3 -> clk_q rises 1 cycle after rst falls; period 3 cycles, high 1; tick_o aligned with each rise; div_cur_o=3.
- Load div_i=4 mid-period of N=3 -> current 3-cycle period completes; next period 4 cycles high 2/low 2; load_pending_o high from load to that wrap.
- Load div_i=1, then div_i=0 -> div_err_o pulses each time; div_cur_o and the waveform are unchanged.
- en_i dropped at cnt=1 with N=6 -> period finishes; running_o=0 and clk_q=0 held; en_i reasserted -> clk_q rises next edge.
- rst asserted mid-high phase with N=8 -> clk_q=0 at that edge; div_cur_o=DEFAULT_DIV; pending cleared.
- Macro defined, N=5 -> clk_q high 2.5 cycles, low 2.5; N=4 unchanged at 2/2.
